fp_posit_acc: RTL and testbench
===============================

// Module: fp_posit_acc
// PURPOSE
//  Accumulator stage directly downstream of fp_posit_mul. Consumes its sign/exp/mantissa/zero/NaR
//  product stream on each done pulse and aligns every product into a signed fixed-point word.
//  Sums a programmed number of products and presents the dot-product result with a one-cycle valid strobe.
// PARAMETERS
//  EXP_WIDTH  5   width of exp_in, two's complement unbiased exponent
//  MAN_W      14  width of man_in, unsigned magnitude
//  MAN_FRAC   12  fractional bits of man_in (0x1000 = 1.0)
//  ACC_WIDTH  32  accumulator width, two's complement
//  ACC_FRAC   16  fractional bits of acc_out
//  LEN_WIDTH  8   width of len
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          asynchronous reset, active-low
//  start      in   1          begin a new accumulation of len products
//  len        in   LEN_WIDTH  number of products to accumulate, sampled on start
//  in_valid   in   1          product strobe (driven by fp_posit_mul done)
//  sign_in    in   1          product sign
//  exp_in     in   EXP_WIDTH  product exponent, signed
//  man_in     in   MAN_W      product mantissa magnitude
//  zero_in    in   1          product is zero; exp_in and man_in are ignored
//  nar_in     in   1          product is NaR; exp_in and man_in are ignored
//  busy       out  1          high from the cycle after an accepted start until acc_valid
//  acc_out    out  ACC_WIDTH  accumulated sum; held until the next accepted start
//  acc_valid  out  1          one-cycle strobe marking acc_out final
//  nar_out    out  1          sticky: at least one NaR product seen in this run
//  ovf_out    out  1          sticky: overflow seen in this run
// BEHAVIOUR
//  Reset: state IDLE. busy, acc_out, acc_valid, nar_out and ovf_out all 0. Count and pipeline registers cleared.
//  FSM states: IDLE -> ACCUM -> DRAIN -> DONE -> IDLE.
//  IDLE:
//   - start accepted. acc, nar_out, ovf_out and the pipeline are cleared. count <= len.
//   - len == 0: go to DONE. acc_valid pulses 1 cycle later with acc_out = 0.
//   - in_valid is ignored.
//  start outside IDLE is ignored.
//  ACCUM: each in_valid is accepted and count is decremented. The last accepted product moves the FSM to DRAIN.
//  Stage 1 (align) registers a signed term:
//   - sh = $signed(exp_in) + (ACC_FRAC - MAN_FRAC).
//   - sh >= 0: mag = man_in << sh. sh < 0: mag = man_in >> -sh, truncating the magnitude.
//   - Alignment is computed in ACC_WIDTH+MAN_W bits. term = sign_in ? -mag : mag.
//   - zero_in: term = 0. nar_in: term = 0 and the NaR flag is set. nar_in has priority over zero_in.
//  Stage 2 (add): acc <= acc + term with ACC_WIDTH+1-bit overflow detect.
//   - mag out of range also flags overflow.
//  DRAIN: 1 cycle for stage 2. DONE: acc_valid = 1 for exactly 1 cycle, busy = 0, then IDLE.
//  Latency: last accepted in_valid on edge T -> acc_valid high after edge T+2. Back-to-back in_valid every cycle is supported.
//  When nar_out = 1, acc_out is forced to 1 << (ACC_WIDTH-1), the NaR pattern.
//  rst asserted mid-run aborts the run. All state returns to reset values and no acc_valid is issued.
// CONFIGURATION
//  FP_POSIT_ACC_SAT_EN
//   - Defined: on overflow, acc clamps to 0x7FFF_FFFF (positive) or 0x8000_0000 (negative) and stays saturated
//     until a term of the opposite sign brings it back into range. ovf_out is set.
//   - Undefined: acc wraps modulo 2^ACC_WIDTH. ovf_out is still set on overflow.
// TESTING
//  1. len=3. Products (s,e,m) = (0,0,0x1000), (0,0,0x1000), (1,0,0x1000)
//     -> acc_out = 0x0001_0000, acc_valid 2 cycles after the 3rd in_valid.
//  2. len=1. Product (0, 5'b11011, 14'b01001010011100) -> acc_out = 0x0000_094E, nar_out = 0, ovf_out = 0.
//  3. len=2. Second product has zero_in=1 with man_in=0x3FFF -> acc_out equals the first term only.
//     Then a new start with len=1 and nar_in=1 -> nar_out = 1, acc_out = 0x8000_0000.
//  4. len=1. Product (0, 5'd15, 0x3FFF).
//     With SAT_EN: acc_out = 0x7FFF_FFFF, ovf_out = 1. Without SAT_EN: ovf_out = 1, wrapped value.
//  5. Mid-run checks:
//     - start pulsed during ACCUM is ignored and the count continues.
//     - rst asserted mid-run gives all outputs 0 with no acc_valid.
//     - len=0 -> acc_valid 1 cycle after start with acc_out = 0.
//  6. Chain fp_posit_mul -> fp_posit_acc. len=4 with 4 back-to-back done pulses
//     -> acc_out equals the golden-model sum of the 4 products.

Source files
------------

// File: rtl/fp_posit_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_posit_acc                                                               |
// | Dot-product accumulator for the fp_posit_mul product stream. Optional      |
// | saturation is enabled with `define FP_POSIT_ACC_SAT_EN.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fp_posit_acc #(
   parameter int EXP_WIDTH = 5,
   parameter int MAN_W     = 14,
   parameter int MAN_FRAC  = 12,
   parameter int ACC_WIDTH = 32,
   parameter int ACC_FRAC  = 16,
   parameter int LEN_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] len,
   input  logic                 in_valid,
   input  logic                 sign_in,
   input  logic [EXP_WIDTH-1:0] exp_in,
   input  logic [MAN_W-1:0]     man_in,
   input  logic                 zero_in,
   input  logic                 nar_in,
   output logic                 busy,
   output logic [ACC_WIDTH-1:0] acc_out,
   output logic                 acc_valid,
   output logic                 nar_out,
   output logic                 ovf_out
);

   localparam int c_AW = ACC_WIDTH + MAN_W;
   localparam logic [ACC_WIDTH-1:0] c_NAR = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`ifdef FP_POSIT_ACC_SAT_EN
   localparam logic [ACC_WIDTH-1:0] c_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
`endif

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ACCUM = 2'd1;
   localparam logic [1:0] c_DRAIN = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   logic [1:0]           r_state;
   logic [LEN_WIDTH-1:0] r_count;
   logic                 r_busy;
   logic                 r_acc_valid;
   logic                 r_nar;
   logic                 r_ovf;
   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_term_v;
   logic                 r_term_nar;
   logic                 r_term_ovf;
   logic [ACC_WIDTH-1:0] r_term;

   int                   w_sh;
   logic [c_AW-1:0]      w_mag;
   logic signed [c_AW:0] w_term_wide;
   logic                 w_rng;
   logic [ACC_WIDTH-1:0] w_term;
   logic [ACC_WIDTH:0]   w_sum;
   logic                 w_add_ovf;
   logic [ACC_WIDTH-1:0] w_acc_next;

   // Stage 1: align the product onto the accumulator's binary point
   always_comb begin
      w_sh  = int'($signed(exp_in)) + (ACC_FRAC - MAN_FRAC);
      w_mag = '0;
      if (w_sh >= 0)
         w_mag = c_AW'(man_in) << w_sh;
      else
         w_mag = c_AW'(man_in) >> (-w_sh);
      w_term_wide = sign_in ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
      // In range only when every bit above the accumulator sign bit matches it
      w_rng  = !((&w_term_wide[c_AW:ACC_WIDTH-1]) || (~|w_term_wide[c_AW:ACC_WIDTH-1]));
      w_term = w_term_wide[ACC_WIDTH-1:0];
`ifdef FP_POSIT_ACC_SAT_EN
      if (w_rng)
         w_term = sign_in ? c_NAR : c_MAX;
`endif
      if (nar_in || zero_in) begin
         w_term = '0;
         w_rng  = 1'b0;
      end
   end

   // Stage 2: add with one guard bit for overflow detection
   always_comb begin
      w_sum      = {r_acc[ACC_WIDTH-1], r_acc} + {r_term[ACC_WIDTH-1], r_term};
      w_add_ovf  = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
      w_acc_next = w_sum[ACC_WIDTH-1:0];
`ifdef FP_POSIT_ACC_SAT_EN
      if (w_add_ovf)
         w_acc_next = w_sum[ACC_WIDTH] ? c_NAR : c_MAX;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= c_IDLE;
         r_count     <= '0;
         r_busy      <= 1'b0;
         r_acc_valid <= 1'b0;
         r_nar       <= 1'b0;
         r_ovf       <= 1'b0;
         r_acc       <= '0;
         r_term_v    <= 1'b0;
         r_term_nar  <= 1'b0;
         r_term_ovf  <= 1'b0;
         r_term      <= '0;
      end else begin
         r_acc_valid <= 1'b0;
         r_term_v    <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_acc      <= '0;
                  r_nar      <= 1'b0;
                  r_ovf      <= 1'b0;
                  r_term     <= '0;
                  r_term_nar <= 1'b0;
                  r_term_ovf <= 1'b0;
                  r_count    <= len;
                  r_busy     <= 1'b1;
                  r_state    <= (len == '0) ? c_DONE : c_ACCUM;
               end
            end
            c_ACCUM: begin
               if (in_valid) begin
                  r_term_v   <= 1'b1;
                  r_term     <= w_term;
                  r_term_nar <= nar_in;
                  r_term_ovf <= w_rng;
                  r_count    <= r_count - 1'b1;
                  if (r_count == LEN_WIDTH'(1))
                     r_state <= c_DRAIN;
               end
            end
            c_DRAIN: r_state <= c_DONE;
            c_DONE: begin
               r_acc_valid <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= c_IDLE;
            end
            default: r_state <= c_IDLE;
         endcase
         if (r_term_v) begin
            r_acc <= w_acc_next;
            if (r_term_nar)
               r_nar <= 1'b1;
            if (r_term_ovf || w_add_ovf)
               r_ovf <= 1'b1;
         end
      end
   end

   assign busy      = r_busy;
   assign acc_valid = r_acc_valid;
   assign nar_out   = r_nar;
   assign ovf_out   = r_ovf;
   assign acc_out   = r_nar ? c_NAR : r_acc;

endmodule
`default_nettype wire

// File: tb/tb_fp_posit_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fp_posit_acc                                                            |
// | Directed self-checking bench for fp_posit_acc.                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fp_posit_acc;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  len = '0;
   logic        in_valid = 1'b0;
   logic        sign_in = 1'b0;
   logic [4:0]  exp_in = '0;
   logic [13:0] man_in = '0;
   logic        zero_in = 1'b0;
   logic        nar_in = 1'b0;
   logic        busy;
   logic [31:0] acc_out;
   logic        acc_valid;
   logic        nar_out;
   logic        ovf_out;

   int n_tests = 0;
   int n_fail  = 0;

   fp_posit_acc dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
      .sign_in(sign_in), .exp_in(exp_in), .man_in(man_in), .zero_in(zero_in),
      .nar_in(nar_in), .busy(busy), .acc_out(acc_out), .acc_valid(acc_valid),
      .nar_out(nar_out), .ovf_out(ovf_out)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start_run(input logic [7:0] l);
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b1;
      len      = l;
   endtask

   task automatic put(input logic s, input logic [4:0] e, input logic [13:0] m,
                      input logic z, input logic n);
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      sign_in  = s;
      exp_in   = e;
      man_in   = m;
      zero_in  = z;
      nar_in   = n;
   endtask

   // Waits for acc_valid, then checks latency, results and the one-cycle strobe
   task automatic finish_run(input string tag, input int exp_lat, input logic [31:0] exp_acc,
                             input logic exp_nar, input logic exp_ovf);
      int lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         start    = 1'b0;
         if (acc_valid) begin
            lat = k;
            break;
         end
      end
      check_eq({tag, "_lat"}, lat, exp_lat);
      check_eq({tag, "_acc"}, acc_out, exp_acc);
      check_eq({tag, "_nar"}, nar_out, exp_nar);
      check_eq({tag, "_ovf"}, ovf_out, exp_ovf);
      check_eq({tag, "_busy"}, busy, 1'b0);
      @(negedge clk);
      check_eq({tag, "_strobe"}, acc_valid, 1'b0);
      check_eq({tag, "_hold"}, acc_out, exp_acc);
   endtask

   initial begin
      logic seen;
      #1;
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_acc", acc_out, 32'h0);
      check_eq("rst_valid", acc_valid, 1'b0);
      check_eq("rst_flags", {nar_out, ovf_out}, 2'b00);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // 1 + 1 - 1 in Q.16
      start_run(8'd3);
      put(1'b0, 5'd0, 14'h1000, 1'b0, 1'b0);
      check_eq("t1_busy", busy, 1'b1);
      put(1'b0, 5'd0, 14'h1000, 1'b0, 1'b0);
      put(1'b1, 5'd0, 14'h1000, 1'b0, 1'b0);
      finish_run("t1", 3, 32'h0001_0000, 1'b0, 1'b0);

      // exp -5 shifts right by one: 0x129C >> 1
      start_run(8'd1);
      put(1'b0, 5'b11011, 14'b01001010011100, 1'b0, 1'b0);
      finish_run("t2", 3, 32'h0000_094E, 1'b0, 1'b0);

      // zero product ignores its mantissa
      start_run(8'd2);
      put(1'b0, 5'd0, 14'h1800, 1'b0, 1'b0);
      put(1'b1, 5'd7, 14'h3FFF, 1'b1, 1'b0);
      finish_run("t3z", 3, 32'h0001_8000, 1'b0, 1'b0);

      start_run(8'd1);
      put(1'b0, 5'd3, 14'h3FFF, 1'b1, 1'b1);
      finish_run("t3nar", 3, 32'h8000_0000, 1'b1, 1'b0);

      // 0x3FFF << 19 exceeds the accumulator range
      start_run(8'd1);
      put(1'b0, 5'd15, 14'h3FFF, 1'b0, 1'b0);
`ifdef FP_POSIT_ACC_SAT_EN
      finish_run("t4", 3, 32'h7FFF_FFFF, 1'b0, 1'b1);
`else
      finish_run("t4", 3, 32'hFFF8_0000, 1'b0, 1'b1);
`endif

      // flags clear on the next run; negative term with right-shift truncation
      start_run(8'd1);
      put(1'b1, 5'b10100, 14'h1FFF, 1'b0, 1'b0);
      finish_run("t4clr", 3, 32'hFFFF_FFE1, 1'b0, 1'b0);

      // start during ACCUM must not restart the count
      start_run(8'd2);
      put(1'b0, 5'd0, 14'h1000, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b1;
      len      = 8'd5;
      put(1'b0, 5'd0, 14'h1000, 1'b0, 1'b0);
      finish_run("t5start", 3, 32'h0002_0000, 1'b0, 1'b0);

      // asynchronous reset mid-run
      start_run(8'd3);
      put(1'b0, 5'd0, 14'h1000, 1'b0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b0;
      #1;
      check_eq("t5rst_busy", busy, 1'b0);
      check_eq("t5rst_acc", acc_out, 32'h0);
      check_eq("t5rst_flags", {acc_valid, nar_out, ovf_out}, 3'b000);
      @(negedge clk);
      rst  = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         seen = seen | acc_valid;
      end
      check_eq("t5rst_novalid", seen, 1'b0);

      start_run(8'd0);
      finish_run("t5len0", 2, 32'h0, 1'b0, 1'b0);

      // four back-to-back products: 0x30000 - 0x4000 + 0x1F - 0x100000
      start_run(8'd4);
      put(1'b0, 5'd1,     14'h1800, 1'b0, 1'b0);
      put(1'b1, 5'b11110, 14'h1000, 1'b0, 1'b0);
      put(1'b0, 5'b10100, 14'h1FFF, 1'b0, 1'b0);
      put(1'b1, 5'd3,     14'h2000, 1'b0, 1'b0);
      finish_run("t6", 3, 32'hFFF2_C01F, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
